// File: rtl/multisum_pkg.sv
// Shared types and constants for the MultiSum arbiter slice.
package multisum_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned N_OPS       = 4;
  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_arbiter
  import multisum_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant_c,
  output logic [IW-1:0]    winner_c,
  output logic             valid_c
);

  int unsigned idx;

  always_comb begin
    grant_c  = '0;
    winner_c = '0;
    valid_c  = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(ptr) + off) % N_REQ;
      if (!valid_c && req[IW'(idx)]) begin
        valid_c              = 1'b1;
        winner_c             = IW'(idx);
        grant_c[IW'(idx)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multisum_arbiter.sv
// Round-robin front end that time-shares one MultiSum adder among N_REQ requesters.
module multisum_arbiter
  import multisum_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*N_OPS*WIDTH-1:0] req_ops,
  output logic [N_REQ-1:0]             ack,
  output logic [N_REQ-1:0]             rsp_valid,
  output logic [WIDTH-1:0]             rsp_sum,
  output logic                         rsp_err,
  output logic [WIDTH-1:0]             ms_in0,
  output logic [WIDTH-1:0]             ms_in1,
  output logic [WIDTH-1:0]             ms_in2,
  output logic [WIDTH-1:0]             ms_in3,
  output logic                         ms_start,
  input  logic [WIDTH-1:0]             ms_sum,
  input  logic                         ms_done,
  output logic                         busy
);

  localparam int unsigned IW  = $clog2(N_REQ);
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);
  localparam int unsigned OPW = N_OPS * WIDTH;

  state_t state, state_next;

  logic [IW-1:0]    ptr, ptr_d;
  logic [IW-1:0]    winner, winner_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             done_q;

  logic [N_REQ-1:0] grant_c;
  logic [IW-1:0]    win_c;
  logic             any_c;
  logic             done_rise_c;
  logic             timeout_c;

  logic [N_REQ-1:0]            ack_d, rsp_valid_d;
  logic [WIDTH-1:0]            rsp_sum_d;
  logic                        rsp_err_d, ms_start_d, busy_d;
  logic [N_OPS-1:0][WIDTH-1:0] ops_d;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req      (req),
    .ptr      (ptr),
    .grant_c  (grant_c),
    .winner_c (win_c),
    .valid_c  (any_c)
  );

  // A done level already high when the op was issued has done_q set, so it never counts.
  assign done_rise_c = ms_done & ~done_q;
  assign timeout_c   = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_c) state_next = GRANT;
      GRANT:   state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (done_rise_c || timeout_c) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath, keyed on the current state.
  always_comb begin
    ack_d       = '0;
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum;
    rsp_err_d   = rsp_err;
    ms_start_d  = (state == GRANT);
    busy_d      = (state_next != IDLE);
    ops_d       = {ms_in3, ms_in2, ms_in1, ms_in0};
    ptr_d       = ptr;
    winner_d    = winner;
    cnt_d       = cnt;
    unique case (state)
      IDLE: begin
        if (any_c) begin
          ack_d    = grant_c;
          winner_d = win_c;
          ptr_d    = (win_c == IW'(N_REQ - 1)) ? '0 : win_c + IW'(1);
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) ops_d = req_ops[i*OPW +: OPW];
          end
        end
      end
      GRANT, ISSUE: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt + CW'(1);
        if (done_rise_c) begin
          rsp_sum_d           = ms_sum;
          rsp_err_d           = 1'b0;
          rsp_valid_d[winner] = 1'b1;
        end else if (timeout_c) begin
          rsp_sum_d           = '0;
          rsp_err_d           = 1'b1;
          rsp_valid_d[winner] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= '0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_err   <= 1'b0;
      ms_in0    <= '0;
      ms_in1    <= '0;
      ms_in2    <= '0;
      ms_in3    <= '0;
      ms_start  <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
      winner    <= '0;
      cnt       <= '0;
      done_q    <= 1'b0;
    end else begin
      ack       <= ack_d;
      rsp_valid <= rsp_valid_d;
      rsp_sum   <= rsp_sum_d;
      rsp_err   <= rsp_err_d;
      ms_in0    <= ops_d[0];
      ms_in1    <= ops_d[1];
      ms_in2    <= ops_d[2];
      ms_in3    <= ops_d[3];
      ms_start  <= ms_start_d;
      busy      <= busy_d;
      ptr       <= ptr_d;
      winner    <= winner_d;
      cnt       <= cnt_d;
      done_q    <= ms_done;
    end
  end

endmodule
